// File: rtl/acc_tile_sequencer.sv
// acc_tile_sequencer: clear/accumulate/present control for one accumulator tile.
// Optional ACC_SEQ_STALL_CNT_EN adds stall_cnt_o (upstream/downstream stall cycles).
module acc_tile_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_len_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             acc_clr_o,
    output logic             acc_en_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             len_err_o,
`ifdef ACC_SEQ_STALL_CNT_EN
    output logic [15:0]      stall_cnt_o,
`endif
    output logic [CNT_W-1:0] beat_cnt_o
);
    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, OUT} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] len_q, beat_cnt_q;
    logic             done_q, len_err_q;
    logic             go;

    assign go = state_q == IDLE && start_i && cfg_len_i != '0;

    // Handshake outputs decode from registered state; abort only suppresses the load.
    assign in_ready_o  = state_q == ACCUM;
    assign acc_clr_o   = state_q == CLEAR;
    assign acc_en_o    = state_q == ACCUM && in_valid_i && !abort_i;
    assign out_valid_o = state_q == OUT;
    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign len_err_o   = len_err_q;
    assign beat_cnt_o  = beat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            if (abort_i && state_q != IDLE) begin
                state_q    <= IDLE;
                beat_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (go) begin
                            len_q      <= cfg_len_i;
                            beat_cnt_q <= '0;
                            state_q    <= CLEAR;
                        end else if (start_i) begin
                            len_err_q <= 1'b1;
                        end
                    end
                    CLEAR: state_q <= ACCUM;
                    ACCUM: begin
                        if (in_valid_i) begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                            if (beat_cnt_q == len_q - CNT_W'(1)) state_q <= OUT;
                        end
                    end
                    OUT: begin
                        if (out_ready_i) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef ACC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_inc;

    assign stall_inc   = (state_q == ACCUM && !in_valid_i) || (state_q == OUT && !out_ready_i);
    assign stall_d     = go ? 16'h0 : (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'h1 : stall_q;
    assign stall_cnt_o = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 16'h0;
        else        stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_acc_tile_sequencer.sv
// tb_acc_tile_sequencer: table vectors, corner sequences and random stimulus
// checked against a tile-level behavioural model.
module tb_acc_tile_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] cfg_len = '0;
    logic       in_ready, acc_clr, acc_en, out_valid, busy, done, len_err;
    logic [7:0] beat_cnt;
`ifdef ACC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    acc_tile_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .cfg_len_i(cfg_len), .abort_i(abort),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .acc_clr_o(acc_clr), .acc_en_o(acc_en),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy), .done_o(done),
        .len_err_o(len_err),
`ifdef ACC_SEQ_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .beat_cnt_o(beat_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, en_count = 0, done_count = 0;

    // Tile-level model: a tile is active, has an age (0 = clearing) and beats taken.
    bit m_active, m_done, m_err;
    int m_age, m_beats, m_len, m_stall;

    function automatic logic [14:0] model_out(input logic iv, input logic ab);
        bit clr  = m_active && m_age == 0;
        bit acc  = m_active && m_age > 0 && m_beats < m_len;
        bit outp = m_active && m_age > 0 && m_beats == m_len;
        return {acc, clr, acc && iv && !ab, outp, m_active, m_done, m_err, 8'(m_beats)};
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_age = 0; m_beats = 0; m_len = 0; m_stall = 0;
    endtask

    task automatic model_tick(input logic st, input logic [7:0] len, input logic ab, input logic iv, input logic ordy);
        bit acc  = m_active && m_age > 0 && m_beats < m_len;
        bit outp = m_active && m_age > 0 && m_beats == m_len;
        if (!m_active && st && len != 0) m_stall = 0;
        else if ((acc && !iv) || (outp && !ordy)) m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
        m_done = 0;
        m_err = 0;
        if (!m_active) begin
            if (st && len != 0) begin
                m_active = 1; m_age = 0; m_beats = 0; m_len = int'(len);
            end else if (st) begin
                m_err = 1;
            end
        end else if (ab) begin
            m_active = 0; m_beats = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (acc) begin
            if (iv) m_beats++;
        end else if (ordy) begin
            m_active = 0; m_done = 1;
        end
    endtask

    // Called at a negedge: drive, check, then advance one clock.
    task automatic step(input logic st, input logic [7:0] len, input logic ab, input logic iv,
                        input logic ordy, input string nm, input bit use_tab, input logic [14:0] tab_exp);
        logic [14:0] exp, got;
        start = st; cfg_len = len; abort = ab; in_valid = iv; out_ready = ordy;
        #1;
        exp = use_tab ? tab_exp : model_out(iv, ab);
        got = {in_ready, acc_clr, acc_en, out_valid, busy, done, len_err, beat_cnt};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got {rdy,clr,en,ov,busy,done,err,cnt}=%b want %b", nm, $time, got, exp);
        end
`ifdef ACC_SEQ_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 16'(m_stall)) begin
            miscompares++;
            $display("FAIL %s stall_cnt @%0t: got %0d want %0d", nm, $time, stall_cnt, m_stall);
        end
`endif
        if (acc_en === 1'b1) en_count++;
        if (done === 1'b1) done_count++;
        @(posedge clk);
        model_tick(st, len, ab, iv, ordy);
        @(negedge clk);
    endtask

    task automatic m(input logic st, input logic [7:0] len, input logic ab, input logic iv, input logic ordy, input string nm);
        step(st, len, ab, iv, ordy, nm, 1'b0, 15'h0);
    endtask

    task automatic expect_int(input int got, input int want, input string nm);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    typedef struct {
        logic       st;
        logic [7:0] len;
        logic       iv, ordy;
        logic [6:0] ctl;
        logic [7:0] cnt;
    } vec_t;
    vec_t tab[10];

    initial begin
        logic [3:0] pat[7];
        tab[0] = '{1'b1, 8'd3, 1'b1, 1'b1, 7'b0000000, 8'd0};
        tab[1] = '{1'b0, 8'd9, 1'b1, 1'b1, 7'b0100100, 8'd0};
        tab[2] = '{1'b0, 8'd9, 1'b1, 1'b1, 7'b1010100, 8'd0};
        tab[3] = '{1'b0, 8'd9, 1'b1, 1'b1, 7'b1010100, 8'd1};
        tab[4] = '{1'b0, 8'd9, 1'b1, 1'b1, 7'b1010100, 8'd2};
        tab[5] = '{1'b0, 8'd9, 1'b1, 1'b1, 7'b0001100, 8'd3};
        tab[6] = '{1'b0, 8'd0, 1'b0, 1'b0, 7'b0000010, 8'd3};
        tab[7] = '{1'b1, 8'd0, 1'b0, 1'b0, 7'b0000000, 8'd3};
        tab[8] = '{1'b0, 8'd0, 1'b0, 1'b0, 7'b0000001, 8'd3};
        tab[9] = '{1'b0, 8'd0, 1'b0, 1'b0, 7'b0000000, 8'd3};
        model_reset();
        @(negedge clk);
        m(1, 8'd3, 0, 1, 1, "reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++)
            step(tab[i].st, tab[i].len, 1'b0, tab[i].iv, tab[i].ordy, $sformatf("table[%0d]", i), 1'b1, {tab[i].ctl, tab[i].cnt});
        for (int i = 0; i < 10; i++) model_tick(tab[i].st, tab[i].len, 1'b0, tab[i].iv, tab[i].ordy);
        // model was replayed separately; resync it to the table's end state
        model_reset(); m_beats = 3;

        // async reset mid-ACCUM
        m(1, 8'd5, 0, 1, 0, "rst_start");
        m(0, 8'd5, 0, 1, 0, "rst_clear");
        m(0, 8'd5, 0, 1, 0, "rst_beat");
        start = 0; in_valid = 1; #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, acc_clr, acc_en, out_valid, busy, done, len_err, beat_cnt} !== 15'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want all zero", {in_ready, acc_clr, acc_en, out_valid, busy, done, len_err, beat_cnt});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m(0, 8'd0, 0, 1, 0, "after_reset");

        // pattern 1,0,0,1,1,0,1 with len 4
        pat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
        en_count = 0;
        m(1, 8'd4, 0, 0, 0, "pat_start");
        m(0, 8'd4, 0, 0, 0, "pat_clear");
        for (int i = 0; i < 7; i++) m(0, 8'd4, 0, pat[i][0], 0, "pat_beat");
        expect_int(en_count, 4, "pat_acc_en_count");
        expect_int(int'(beat_cnt), 4, "pat_beat_cnt");

        // OUT held 10 cycles then one done
        done_count = 0;
        for (int i = 0; i < 10; i++) m(0, 8'd0, 0, 1, 0, "out_hold");
        m(0, 8'd0, 0, 0, 1, "out_accept");
        m(0, 8'd0, 0, 0, 0, "out_done");
        m(0, 8'd0, 0, 0, 0, "out_idle");
        expect_int(done_count, 1, "out_done_count");

        // start ignored during ACCUM; full 255-beat tile
        en_count = 0;
        m(1, 8'd255, 0, 1, 0, "long_start");
        m(0, 8'd0, 0, 1, 0, "long_clear");
        for (int i = 0; i < 255; i++) m((i == 7) ? 1'b1 : 1'b0, 8'd2, 0, 1, 0, "long_beat");
        expect_int(en_count, 255, "long_acc_en_count");
        m(0, 8'd0, 0, 0, 1, "long_out");
        m(0, 8'd0, 0, 0, 0, "long_done");

        // abort on the 2nd beat, then immediate restart
        en_count = 0; done_count = 0;
        m(1, 8'd4, 0, 1, 1, "abort_start");
        m(0, 8'd4, 0, 1, 1, "abort_clear");
        m(0, 8'd4, 0, 1, 1, "abort_beat1");
        m(0, 8'd4, 1, 1, 1, "abort_beat2");
        m(1, 8'd2, 1, 0, 0, "abort_restart");
        m(0, 8'd2, 0, 0, 0, "abort_clear2");
        expect_int(en_count, 1, "abort_acc_en_count");
        expect_int(done_count, 0, "abort_no_done");

        for (int i = 0; i < 3000; i++)
            m(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom_range(0, 6)),
              ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1'($urandom), 1'($urandom), "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
